// File: rtl/bcd_muldiv_unit_pkg.sv
// Shared definitions for the BCD multiply/divide engine: op codes, flag bit
// positions and FSM state encoding.
package bcd_muldiv_unit_pkg;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_TR   = 1;
    localparam int FLAG_DZ   = 2;
    localparam int FLAG_ERR  = 3;
    localparam int NUM_FLAGS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [NUM_FLAGS-1:0] flag_bit(input int idx);
        logic [NUM_FLAGS-1:0] f;
        f = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/bcd_muldiv_unit_nd_adder.sv
// Ripple-carry packed-BCD adder over NUM_DIGITS digits with carry in/out.
// Purely combinational; a subtraction is done by 9s-complementing b and setting cin.
module bcd_nd_adder #(
    parameter int NUM_DIGITS = 5
) (
    input  logic [NUM_DIGITS*4-1:0] a,
    input  logic [NUM_DIGITS*4-1:0] b,
    input  logic                    cin,
    output logic [NUM_DIGITS*4-1:0] sum,
    output logic                    cout
);

    logic       carry;
    logic [4:0] digit;

    always_comb begin
        carry = cin;
        digit = '0;
        sum   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, carry};
            if (digit > 5'd9) begin
                digit = digit + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[i*4 +: 4] = digit[3:0];
        end
        cout = carry;
    end

endmodule

// File: rtl/bcd_muldiv_unit.sv
// Multi-cycle packed-BCD multiply (add/shift) and restoring divide engine.
// Define BCD_MULDIV_DIV_EN to build the divider; otherwise DIV reports ERR.
module bcd_muldiv_unit
    import bcd_muldiv_unit_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [1:0]              i_op,
    input  logic [NUM_DIGITS*4-1:0] i_num_a,
    input  logic [NUM_DIGITS*4-1:0] i_num_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NUM_DIGITS*4-1:0] o_num_lo,
    output logic [NUM_DIGITS*4-1:0] o_num_hi,
    output logic [NUM_FLAGS-1:0]    o_flags
);

    localparam int W  = NUM_DIGITS * 4;
    localparam int AW = W + 4;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(NUM_DIGITS - 1);

    state_t        state;
    logic [W-1:0]  a_reg;
    // MUL: {carry digit, HI} / LO of the product. DIV: R (ND+1 digits) / Q.
    logic [AW-1:0] acc_hi;
    logic [W-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic [AW-1:0] add_sum;
    logic          add_cin;
    logic          add_cout;

    logic          mul_add;
    logic [W-1:0]  mul_sh_hi;
    logic [W-1:0]  mul_sh_lo;
    logic [NUM_FLAGS-1:0] mul_flags;

`ifdef BCD_MULDIV_DIV_EN
    logic [W-1:0]  b_reg;
    logic          div_shift;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] b_nines;
`else
    logic          unused_cout;
    assign unused_cout = add_cout;
`endif

    // Digits above 9 are skipped rather than counted down so that bad
    // operands still finish inside the normal cycle bound.
    assign mul_add   = (acc_lo[3:0] != 4'd0) && (acc_lo[3:0] <= 4'd9);
    assign mul_sh_hi = acc_hi[AW-1:4];
    assign mul_sh_lo = {acc_hi[3:0], acc_lo[W-1:4]};

    always_comb begin
        mul_flags          = '0;
        mul_flags[FLAG_Z]  = ({mul_sh_hi, mul_sh_lo} == '0);
        mul_flags[FLAG_TR] = (mul_sh_hi != '0);
    end

    always_comb begin
        add_a   = acc_hi;
        add_b   = {4'h0, a_reg};
        add_cin = 1'b0;
`ifdef BCD_MULDIV_DIV_EN
        b_ext   = {4'h0, b_reg};
        b_nines = '0;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            b_nines[i*4 +: 4] = 4'd9 - b_ext[i*4 +: 4];
        end
        if (state == ST_DIV) begin
            add_b   = b_nines;
            add_cin = 1'b1;
        end
`endif
    end

    bcd_nd_adder #(
        .NUM_DIGITS (NUM_DIGITS + 1)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_num_lo <= '0;
            o_num_hi <= '0;
            o_flags  <= '0;
            a_reg    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
`ifdef BCD_MULDIV_DIV_EN
            b_reg     <= '0;
            div_shift <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_reg   <= i_num_a;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        acc_hi  <= '0;
                        case (i_op)
                            OP_MUL: begin
                                acc_lo <= i_num_b;
                                state  <= ST_MUL;
                            end
`ifdef BCD_MULDIV_DIV_EN
                            OP_DIV: begin
                                acc_lo    <= i_num_a;
                                b_reg     <= i_num_b;
                                div_shift <= 1'b1;
                                state     <= ST_DIV;
                            end
`endif
                            default: begin
                                o_num_lo <= '0;
                                o_num_hi <= '0;
                                o_flags  <= flag_bit(FLAG_ERR);
                                o_valid  <= 1'b1;
                                state    <= ST_DONE;
                            end
                        endcase
                    end
                end

                ST_MUL: begin
                    if (mul_add) begin
                        acc_hi      <= add_sum;
                        acc_lo[3:0] <= acc_lo[3:0] - 4'd1;
                    end else begin
                        acc_hi <= {4'h0, mul_sh_hi};
                        acc_lo <= mul_sh_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            o_num_lo <= mul_sh_lo;
                            o_num_hi <= mul_sh_hi;
                            o_flags  <= mul_flags;
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end

`ifdef BCD_MULDIV_DIV_EN
                ST_DIV: begin
                    if (b_reg == '0) begin
                        o_num_lo <= '0;
                        o_num_hi <= a_reg;
                        o_flags  <= flag_bit(FLAG_DZ);
                        o_valid  <= 1'b1;
                        state    <= ST_DONE;
                    end else if (div_shift) begin
                        acc_hi    <= {acc_hi[W-1:0], acc_lo[W-1 -: 4]};
                        acc_lo    <= {acc_lo[W-5:0], 4'h0};
                        div_shift <= 1'b0;
                    // Cap the quotient digit at 9 so bad operands cannot spin.
                    end else if (add_cout && (acc_lo[3:0] != 4'd9)) begin
                        acc_hi      <= add_sum;
                        acc_lo[3:0] <= acc_lo[3:0] + 4'd1;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        div_shift <= 1'b1;
                        if (cnt == LAST_STEP) begin
                            o_num_lo <= acc_lo;
                            o_num_hi <= acc_hi[W-1:0];
                            o_flags  <= (acc_lo == '0) ? flag_bit(FLAG_Z) : '0;
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
`endif

                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_muldiv_unit.sv
// Directed bench for bcd_muldiv_unit (NUM_DIGITS=4), expectations follow the
// BCD_MULDIV_DIV_EN setting of the build.
module tb_bcd_muldiv_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [15:0] i_num_a;
    logic [15:0] i_num_b;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_num_lo;
    logic [15:0] o_num_hi;
    logic [3:0]  o_flags;

    int tests = 0;
    int fails = 0;

    bcd_muldiv_unit #(.NUM_DIGITS(4)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_num_a  (i_num_a),
        .i_num_b  (i_num_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_num_lo (o_num_lo),
        .o_num_hi (o_num_hi),
        .o_flags  (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE; lat = rising edges from the accepting edge
    // (counted as 1) until o_valid is seen.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b, output int lat);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_op    = op;
        i_num_a = a;
        i_num_b = b;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
    endtask

    task automatic check_res(input string tag, input int lat, input int exp_lat,
                             input logic [15:0] lo, input logic [15:0] hi, input logic [3:0] fl);
        check({tag, "_lat"},   32'(lat),      32'(exp_lat));
        check({tag, "_lo"},    32'(o_num_lo), 32'(lo));
        check({tag, "_hi"},    32'(o_num_hi), 32'(hi));
        check({tag, "_flags"}, 32'(o_flags),  32'(fl));
    endtask

    task automatic take();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int stable;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_op    = 2'd0;
        i_num_a = '0;
        i_num_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready),  32'd1);
        check("rst_valid", 32'(o_valid),  32'd0);
        check("rst_lo",    32'(o_num_lo), 32'd0);
        check("rst_hi",    32'(o_num_hi), 32'd0);
        check("rst_flags", 32'(o_flags),  32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // 1234 x 5678 = 7006652, digit sum of B 26 -> 26+4+1
        run_op("mul_a", 2'd0, 16'h1234, 16'h5678, lat);
        check_res("mul_a", lat, 31, 16'h6652, 16'h0700, 4'b0010);
        take();

        run_op("mul_zero", 2'd0, 16'h9999, 16'h0000, lat);
        check_res("mul_zero", lat, 5, 16'h0000, 16'h0000, 4'b0001);
        take();

        // Worst case MUL latency 10*ND+1
        run_op("mul_max", 2'd0, 16'h9999, 16'h9999, lat);
        check_res("mul_max", lat, 41, 16'h0001, 16'h9998, 4'b0010);
        take();

`ifdef BCD_MULDIV_DIV_EN
        run_op("div_a", 2'd1, 16'h9999, 16'h0003, lat);
        check("div_a_lo",    32'(o_num_lo), 32'h3333);
        check("div_a_hi",    32'(o_num_hi), 32'h0000);
        check("div_a_flags", 32'(o_flags),  32'h0);
        check("div_a_bound", 32'(lat <= 45), 32'd1);
        take();

        run_op("div_b", 2'd1, 16'h1000, 16'h0007, lat);
        check("div_b_lo",    32'(o_num_lo), 32'h0142);
        check("div_b_hi",    32'(o_num_hi), 32'h0006);
        check("div_b_flags", 32'(o_flags),  32'h0);
        take();

        run_op("div_dz", 2'd1, 16'h1000, 16'h0000, lat);
        check("div_dz_lat", 32'(lat),        32'd2);
        check("div_dz_lo",  32'(o_num_lo),   32'h0000);
        check("div_dz_hi",  32'(o_num_hi),   32'h1000);
        check("div_dz_dz",  32'(o_flags[2]), 32'd1);
        check("div_dz_err", 32'(o_flags[3]), 32'd0);
        take();
`else
        run_op("div_a", 2'd1, 16'h9999, 16'h0003, lat);
        check_res("div_a", lat, 1, 16'h0000, 16'h0000, 4'b1000);
        take();

        run_op("div_dz", 2'd1, 16'h1000, 16'h0000, lat);
        check_res("div_dz", lat, 1, 16'h0000, 16'h0000, 4'b1000);
        take();
`endif

        run_op("ill", 2'd3, 16'h1234, 16'h0005, lat);
        check_res("ill", lat, 1, 16'h0000, 16'h0000, 4'b1000);
        take();

        // 0012 x 0011 = 132, then hold the result under backpressure
        run_op("bp", 2'd0, 16'h0012, 16'h0011, lat);
        check_res("bp", lat, 7, 16'h0132, 16'h0000, 4'b0000);
        i_op    = 2'd0;
        i_num_a = 16'h0009;
        i_num_b = 16'h0009;
        i_valid = 1'b1;
        stable  = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_num_lo !== 16'h0132 ||
                o_num_hi !== 16'h0000 || o_flags !== 4'b0000)
                stable = 0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        i_valid = 1'b0;
        take();
        check("bp_rel_ready", 32'(o_ready), 32'd1);
        check("bp_rel_valid", 32'(o_valid), 32'd0);

        // Asynchronous abort in the middle of a multiply
        i_op    = 2'd0;
        i_num_a = 16'h1234;
        i_num_b = 16'h5678;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        check("abort_busy", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(o_valid),  32'd0);
        check("abort_ready", 32'(o_ready),  32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("abort_no_result", 32'(o_valid), 32'd0);

        run_op("post", 2'd0, 16'h0002, 16'h0003, lat);
        check_res("post", lat, 8, 16'h0006, 16'h0000, 4'b0000);
        take();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
